fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch and memory-access sequencer for the 8-bit CPU.
- Sits directly upstream of the 16x8 RAM. It owns the RAM address, read_enable, write_enable and bidirectional data bus.
- It holds the program counter and fetches each instruction byte (upper nibble opcode, lower nibble operand). It hands the fields to the decoder over a valid/ready handshake.
- It also services operand reads and writes requested by the execute stage.

Parameters:
- ACCESS_CYCLES, 2: cycles that address and enables are held per RAM access; data is sampled on the last cycle; must be >= 1.
- HALT_OPCODE, 4'hF: opcode that stops fetching.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- run  in  1  permits fetching to start or continue.
- ram_address  out  4  RAM address.
- ram_write_enable  out  1  RAM write strobe.
- ram_read_enable  out  1  RAM read strobe.
- ram_data  inout  8  RAM data bus; driven only during writes, Z otherwise.
- pc  out  4  current program counter.
- ir_valid  out  1  instruction fields valid.
- ir_ready  in  1  decoder accepts the instruction.
- ir_opcode  out  4  fetched byte [7:4].
- ir_operand  out  4  fetched byte [3:0].
- ir_pc  out  4  address the instruction was fetched from.
- mem_req  in  1  execute-stage data access request.
- mem_we  in  1  1 = write, 0 = read; qualified by mem_req.
- mem_addr  in  4  data access address.
- mem_wdata  in  8  write data.
- mem_rdata  out  8  read data; holds until the next read completes.
- mem_done  out  1  one-cycle pulse when a data access completes.
- exec_done  in  1  current instruction finished.
- jump_en  in  1  with exec_done, load pc from jump_addr.
- jump_addr  in  4  jump target.
- halted  out  1  halt opcode accepted.

Behaviour:
Reset (synchronous, rst_n=0 at a posedge):
- State is IDLE; pc, ir_*, mem_rdata and the access counter are 0.
- All strobes, ir_valid, mem_done and halted are 0; ram_data is Z.
- Applies mid-access: enables drop at that edge and the access is abandoned.

States: IDLE, FETCH, ISSUE, EXEC, DATA, HALTED.

IDLE:
- If run=1, go to FETCH; otherwise stay.

FETCH:
- ram_address=pc, ram_read_enable=1, ram_write_enable=0, held exactly ACCESS_CYCLES cycles.
- On the last cycle, capture ram_data into {ir_opcode, ir_operand}, set ir_pc=pc, and set pc=pc+1 mod 16 (15 wraps to 0).
- Go to ISSUE with ir_valid=1 at the next edge.
- Deasserting run mid-fetch does not abort the fetch.

ISSUE:
- ir_valid=1; ir_opcode, ir_operand and ir_pc are stable until the handshake.
- Handshake completes on the first edge where ir_ready=1; ir_valid drops at that edge.
- If ir_opcode==HALT_OPCODE, go to HALTED; otherwise go to EXEC.
- No RAM access occurs in this state.

EXEC (waiting on the execute stage; strobes low):
- mem_req=1: latch mem_we, mem_addr and mem_wdata, then go to DATA.
- Otherwise, exec_done=1: if jump_en=1 set pc=jump_addr (jump_en is ignored without exec_done). Then go to FETCH if run=1, else IDLE.
- mem_req and exec_done in the same cycle: mem_req wins and exec_done is dropped; the execute stage must reassert it.

DATA (ACCESS_CYCLES cycles, ram_address = latched address):
- Read: ram_read_enable=1; ram_data is captured into mem_rdata on the last cycle.
- Write: ram_write_enable=1 and ram_data is driven with the latched wdata for all cycles.
- Return to EXEC with mem_done=1 for exactly one cycle.
- Several accesses per instruction are allowed.

HALTED:
- halted=1, strobes low; run, mem_req and exec_done are ignored.
- Left only by reset.

Invariants:
- ram_read_enable and ram_write_enable are never both 1.
- ram_data is Z in every cycle except DATA-write cycles.
- All outputs are registered.

Test Plan:
- Fetch: reset, then run=1, ACCESS_CYCLES=2, RAM[0]=0x1A -> ram_address=0 with read_enable high for 2 cycles; then ir_valid=1, ir_opcode=1, ir_operand=A, ir_pc=0, pc=1.
- Backpressure: hold ir_ready=0 for 5 cycles after ir_valid -> ir fields and ir_valid stable, both RAM strobes 0; raise ir_ready -> ir_valid drops next edge.
- Data path: in EXEC, read 0xA (RAM=0x03) -> mem_rdata=0x03 with one mem_done pulse. Then write 0x55 to 0xC and read 0xC back -> 0x55. Throughout, enables never both high and ram_data is Z outside write cycles.
- Priority and jump: mem_req together with exec_done+jump_en (addr 0xE) -> the data access happens first and pc is unchanged. Then exec_done+jump_en alone -> next fetch at ram_address=0xE.
- Wrap and stop: fetch at pc=15 -> pc=0. With run=0 at exec_done -> IDLE, no strobes until run=1.
- Halt and reset: RAM byte 0xF0 fetched and accepted -> halted=1, no further RAM activity for 20 cycles. rst_n=0 for one edge -> halted=0, pc=0, state IDLE.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch and RAM access sequencer: owns the RAM port, the program
// counter and the decoder handshake, and runs execute-stage data accesses.
module fetch_unit #(
    parameter int         ACCESS_CYCLES = 2,
    parameter logic [3:0] HALT_OPCODE   = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic [3:0] ram_address,
    output logic       ram_write_enable,
    output logic       ram_read_enable,
    inout  wire  [7:0] ram_data,
    output logic [3:0] pc,
    output logic       ir_valid,
    input  logic       ir_ready,
    output logic [3:0] ir_opcode,
    output logic [3:0] ir_operand,
    output logic [3:0] ir_pc,
    input  logic       mem_req,
    input  logic       mem_we,
    input  logic [3:0] mem_addr,
    input  logic [7:0] mem_wdata,
    output logic [7:0] mem_rdata,
    output logic       mem_done,
    input  logic       exec_done,
    input  logic       jump_en,
    input  logic [3:0] jump_addr,
    output logic       halted
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, EXEC, DATA, HALTED} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_we_q, data_we_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [3:0]       pc_d, addr_d, op_d, opnd_d, irpc_d;
    logic             re_d, we_d, irv_d, done_d, halted_d;
    logic [7:0]       rdata_d;

    assign ram_data = ram_write_enable ? wdata_q : 8'bz;

    // Next-state logic also computes the next value of every output so that
    // the strobes are registered and rise together with the state change.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        data_we_d = data_we_q;
        wdata_d   = wdata_q;
        pc_d      = pc;
        addr_d    = ram_address;
        re_d      = 1'b0;
        we_d      = 1'b0;
        irv_d     = ir_valid;
        op_d      = ir_opcode;
        opnd_d    = ir_operand;
        irpc_d    = ir_pc;
        rdata_d   = mem_rdata;
        done_d    = 1'b0;
        halted_d  = halted;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                    addr_d  = pc;
                    re_d    = 1'b1;
                end
            end
            FETCH: begin
                re_d = 1'b1;
                if (cnt_q == LAST) begin
                    {op_d, opnd_d} = ram_data;
                    irpc_d  = pc;
                    pc_d    = pc + 4'd1;
                    irv_d   = 1'b1;
                    re_d    = 1'b0;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ISSUE: begin
                if (ir_ready) begin
                    irv_d = 1'b0;
                    if (ir_opcode == HALT_OPCODE) begin
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                // A data request takes priority; a coincident exec_done is lost.
                if (mem_req) begin
                    data_we_d = mem_we;
                    wdata_d   = mem_wdata;
                    addr_d    = mem_addr;
                    re_d      = ~mem_we;
                    we_d      = mem_we;
                    state_d   = DATA;
                end else if (exec_done) begin
                    if (jump_en) pc_d = jump_addr;
                    if (run) begin
                        addr_d  = jump_en ? jump_addr : pc;
                        re_d    = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                re_d = ~data_we_q;
                we_d = data_we_q;
                if (cnt_q == LAST) begin
                    if (!data_we_q) rdata_d = ram_data;
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HALTED: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            data_we_q        <= 1'b0;
            wdata_q          <= '0;
            pc               <= '0;
            ram_address      <= '0;
            ram_read_enable  <= 1'b0;
            ram_write_enable <= 1'b0;
            ir_valid         <= 1'b0;
            ir_opcode        <= '0;
            ir_operand       <= '0;
            ir_pc            <= '0;
            mem_rdata        <= '0;
            mem_done         <= 1'b0;
            halted           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            data_we_q        <= data_we_d;
            wdata_q          <= wdata_d;
            pc               <= pc_d;
            ram_address      <= addr_d;
            ram_read_enable  <= re_d;
            ram_write_enable <= we_d;
            ir_valid         <= irv_d;
            ir_opcode        <= op_d;
            ir_operand       <= opnd_d;
            ir_pc            <= irpc_d;
            mem_rdata        <= rdata_d;
            mem_done         <= done_d;
            halted           <= halted_d;
        end
    end

endmodule
